// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: four producers share one FIFO write port.
// Each word is tagged with the producer index; no write is issued while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int unsigned dat_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [3:0]             req,
  input  logic [4*dat_width-1:0] req_data,
  input  logic                   fifo_full,
  output logic [3:0]             ack,
  output logic                   fifo_wr,
  output logic [dat_width+1:0]   fifo_din,
  output logic [1:0]             grant_id,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, WRITE, SETTLE} state_t;

  state_t               state;
  logic [1:0]           rr_ptr;
  logic [1:0]           winner;
  logic                 found;
  logic [1:0]           idx;
  logic [dat_width-1:0] payload;

  // First set request at or above rr_ptr, wrapping modulo 4.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    payload = req_data[32'(winner)*dat_width +: dat_width];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      ack      <= '0;
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !fifo_full && found) begin
            state    <= WRITE;
            grant_id <= winner;
            fifo_din <= {winner, payload};
            ack      <= 4'(1) << winner;
            fifo_wr  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        WRITE: begin
          ack     <= '0;
          fifo_wr <= 1'b0;
          rr_ptr  <= grant_id + 2'd1;
          state   <= SETTLE;
        end
        SETTLE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack     <= '0;
          fifo_wr <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
